// File: rtl/wb_arb2_pkg.sv
// wb_arb2_pkg: grant state encoding shared by the Wishbone arbiters
package wb_arb2_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_e;
endpackage

// File: rtl/wb_arb2_if.sv
// wb_arb2_if: pipelined Wishbone bus; master drives requests, slave returns data/ack/stall
interface wb_arb2_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        stall;
    modport master (output addr, wdata, sel, cti, we, cyc, stb, input rdata, ack, stall);
    modport slave  (input addr, wdata, sel, cti, we, cyc, stb, output rdata, ack, stall);
endinterface

// File: rtl/wb_arb2.sv
// wb_arb2: two-master round-robin pipelined Wishbone arbiter with outstanding-ack tracking
module wb_arb2
    import wb_arb2_pkg::*;
#(
    parameter int OUTST_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    wb_arb2_if.slave    m0,
    wb_arb2_if.slave    m1,
    wb_arb2_if.master   s
);
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    state_e               state_q, state_d;
    logic [OUTST_W-1:0]   outst_q, outst_d;
    logic                 last_q, last_d;
    logic                 full, busy, gnt0, gnt1, own_cyc, own_stb;
    logic                 s_cyc, s_stb, accept, ack_ok, release_ok;

    assign full    = outst_q == OUTST_MAX;
    assign busy    = outst_q != '0;
    assign gnt0    = state_q == ST_GNT0;
    assign gnt1    = state_q == ST_GNT1;
    assign own_cyc = gnt1 ? m1.cyc : m0.cyc;
    assign own_stb = gnt1 ? m1.stb : m0.stb;

    // The granting master's request is forwarded; the pending counter keeps the cycle open for late acks
    assign s_cyc   = (gnt0 | gnt1) & (own_cyc | busy);
    assign s_stb   = (gnt0 | gnt1) & own_cyc & own_stb & !full;
    assign s.cyc   = s_cyc;
    assign s.stb   = s_stb;
    assign s.addr  = gnt1 ? m1.addr  : m0.addr;
    assign s.wdata = gnt1 ? m1.wdata : m0.wdata;
    assign s.sel   = gnt1 ? m1.sel   : m0.sel;
    assign s.cti   = gnt1 ? m1.cti   : m0.cti;
    assign s.we    = gnt1 ? m1.we    : m0.we;

    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.ack   = gnt0 & s.ack & m0.cyc;
    assign m1.ack   = gnt1 & s.ack & m1.cyc;
    assign m0.stall = !gnt0 | s.stall | full;
    assign m1.stall = !gnt1 | s.stall | full;

    assign accept     = s_cyc & s_stb & !s.stall;
    assign ack_ok     = s.ack & busy;
    assign release_ok = !own_cyc & (!busy | (outst_q == OUTST_W'(1) & s.ack));

    // Outstanding count: accepts add, acks subtract, spurious acks at zero are dropped
    always_comb begin
        outst_d = outst_q;
        if (accept & !ack_ok)
            outst_d = outst_q + OUTST_W'(1);
        else if (ack_ok & !accept)
            outst_d = outst_q - OUTST_W'(1);
    end

    // Grant selection: round-robin on ties, hand-over without idle bubble, no preemption
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc & (!m1.cyc | last_q)) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (m1.cyc) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0: begin
                if (release_ok) begin
                    state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
                    last_d  = m1.cyc ? 1'b1 : last_q;
                end
            end
            ST_GNT1: begin
                if (release_ok) begin
                    state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
                    last_d  = m0.cyc ? 1'b0 : last_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset makes m0 win the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            outst_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed and randomized check of wb_arb2 against a behavioural ownership model
module tb_wb_arb2;
    localparam logic [31:0] KEY = 32'hDEAD_0000;
    localparam int MAXO = 3;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    wb_arb2_if m0_if();
    wb_arb2_if m1_if();
    wb_arb2_if s_if();

    wb_arb2 #(.OUTST_W(2)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int tests = 0;
    int fails = 0;
    int own = -1;
    int outst = 0;
    int last = 1;
    bit auto_ack = 1'b0;
    bit pend = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mcyc(input int n);
        return n == 0 ? m0_if.cyc : m1_if.cyc;
    endfunction

    function automatic bit mstb(input int n);
        return n == 0 ? m0_if.stb : m1_if.stb;
    endfunction

    function automatic logic [31:0] maddr(input int n);
        return n == 0 ? m0_if.addr : m1_if.addr;
    endfunction

    function automatic logic [71:0] mbus(input int n);
        return n == 0 ? {m0_if.addr, m0_if.wdata, m0_if.sel, m0_if.cti, m0_if.we}
                      : {m1_if.addr, m1_if.wdata, m1_if.sel, m1_if.cti, m1_if.we};
    endfunction

    task automatic model_reset();
        own = -1;
        outst = 0;
        last = 1;
        pend = 1'b0;
    endtask

    // Outputs implied by who owns the bus and how many acks are owed
    task automatic model_outputs(output bit scyc, output bit sstb, output bit st0, output bit st1,
                                 output bit a0, output bit a1);
        bit c, full;
        full = outst == MAXO;
        scyc = 0; sstb = 0; st0 = 1; st1 = 1; a0 = 0; a1 = 0;
        if (own >= 0) begin
            c = mcyc(own);
            scyc = c || outst != 0;
            sstb = c && mstb(own) && !full;
            if (own == 0) begin
                st0 = s_if.stall || full;
                a0 = s_if.ack && c;
            end else begin
                st1 = s_if.stall || full;
                a1 = s_if.ack && c;
            end
        end
    endtask

    task automatic model_check();
        bit scyc, sstb, st0, st1, a0, a1;
        if (!rst_ni) model_reset();
        model_outputs(scyc, sstb, st0, st1, a0, a1);
        chk("s_cyc", s_if.cyc, scyc);
        chk("s_stb", s_if.stb, sstb);
        chk("m0_stall", m0_if.stall, st0);
        chk("m1_stall", m1_if.stall, st1);
        chk("m0_ack", m0_if.ack, a0);
        chk("m1_ack", m1_if.ack, a1);
        chk("m0_rdata", m0_if.rdata, s_if.rdata);
        chk("m1_rdata", m1_if.rdata, s_if.rdata);
        if (own >= 0)
            chk("s_bus", {s_if.addr, s_if.wdata, s_if.sel, s_if.cti, s_if.we}, mbus(own));
    endtask

    task automatic model_update();
        bit scyc, sstb, st0, st1, a0, a1, acc, ackv;
        if (!rst_ni) begin
            model_reset();
        end else begin
            model_outputs(scyc, sstb, st0, st1, a0, a1);
            acc = scyc && sstb && !s_if.stall;
            ackv = s_if.ack && outst > 0;
            pend = auto_ack && acc;
            if (acc) pend_data = maddr(own) ^ KEY;
            if (own < 0) begin
                if (m0_if.cyc && m1_if.cyc) own = (last == 1) ? 0 : 1;
                else if (m0_if.cyc) own = 0;
                else if (m1_if.cyc) own = 1;
                if (own >= 0) last = own;
            end else if (!mcyc(own) && (outst == 0 || (outst == 1 && s_if.ack))) begin
                own = mcyc(1 - own) ? 1 - own : -1;
                if (own >= 0) last = own;
            end
            outst += int'(acc) - int'(ackv);
        end
    endtask

    task automatic step();
        #2 model_check();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        if (auto_ack) begin
            s_if.ack = pend;
            s_if.rdata = pend ? pend_data : 32'h0;
        end
    endtask

    task automatic drive(input int n, input bit cyc, input bit stb, input logic [31:0] addr);
        if (n == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.addr = addr;
            m0_if.wdata = ~addr; m0_if.sel = 4'hf; m0_if.cti = 3'd0; m0_if.we = 1'b0;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.addr = addr;
            m1_if.wdata = ~addr; m1_if.sel = 4'hf; m1_if.cti = 3'd0; m1_if.we = 1'b0;
        end
    endtask

    initial begin
        drive(0, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        s_if.stall = 1'b0;
        s_if.ack = 1'b0;
        s_if.rdata = 32'h0;
        auto_ack = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_scyc", s_if.cyc, 0);
        chk("rst_ack0", m0_if.ack, 0);
        chk("rst_ack1", m1_if.ack, 0);
        chk("rst_stall0", m0_if.stall, 1);
        chk("rst_stall1", m1_if.stall, 1);
        step();
        step();
        rst_ni = 1'b1;
        step();
        #1;
        chk("gnt0_stall0", m0_if.stall, 0);
        chk("gnt0_stall1", m1_if.stall, 1);
        chk("gnt0_scyc", s_if.cyc, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'h100 + 32'(4 * i));
            step();
        end
        drive(0, 1, 0, 32'h0);
        #1;
        chk("m0_ack3", m0_if.ack, 1);
        chk("m0_data3", m0_if.rdata, 32'h108 ^ KEY);
        chk("m1_ack_cont", m1_if.ack, 0);
        step();
        drive(0, 0, 0, 32'h0);
        step();
        #1;
        chk("gnt1_nobubble", m1_if.stall, 0);
        chk("gnt1_stall0", m0_if.stall, 1);
        drive(1, 0, 0, 32'h0);
        step();
        drive(0, 1, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        #1;
        chk("idle_stall0", m0_if.stall, 1);
        step();
        #1;
        chk("tie_m0", m0_if.stall, 0);
        chk("tie_m1", m1_if.stall, 1);
        auto_ack = 1'b0;
        s_if.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 32'h200 + 32'(4 * i));
            step();
        end
        drive(0, 1, 1, 32'h20c);
        #1;
        chk("full_stall", m0_if.stall, 1);
        chk("full_stb", s_if.stb, 0);
        step();
        s_if.ack = 1'b1;
        #1;
        chk("full_ack", m0_if.ack, 1);
        chk("full_stall_ack", m0_if.stall, 1);
        step();
        drive(0, 0, 0, 32'h0);
        s_if.ack = 1'b1;
        #1;
        chk("drop_scyc", s_if.cyc, 1);
        chk("drop_ack", m0_if.ack, 0);
        step();
        #1;
        chk("drop_ack2", m0_if.ack, 0);
        chk("drop_hold1", m1_if.stall, 1);
        step();
        s_if.ack = 1'b0;
        #1;
        chk("drop_release", m1_if.stall, 0);
        drive(1, 0, 0, 32'h0);
        step();
        step();
        auto_ack = 1'b1;
        drive(1, 1, 1, 32'h40);
        #1;
        chk("rd_T_stb", s_if.stb, 0);
        step();
        #1;
        chk("rd_T1_stb", s_if.stb, 1);
        step();
        drive(1, 1, 0, 32'h40);
        #1;
        chk("rd_ack", m1_if.ack, 1);
        chk("rd_data", m1_if.rdata, 32'h40 ^ KEY);
        chk("rd_m0ack", m0_if.ack, 0);
        step();
        drive(1, 0, 0, 32'h0);
        step();
        step();
        auto_ack = 1'b0;
        s_if.ack = 1'b1;
        #1;
        chk("spur_ack0", m0_if.ack, 0);
        chk("spur_ack1", m1_if.ack, 0);
        step();
        s_if.ack = 1'b0;
        auto_ack = 1'b1;
        drive(0, 1, 1, 32'h300);
        step();
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk("midrst_scyc", s_if.cyc, 0);
        chk("midrst_stall0", m0_if.stall, 1);
        step();
        rst_ni = 1'b1;
        drive(0, 0, 0, 32'h0);
        step();
        step();
        auto_ack = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) m0_if.cyc = ~m0_if.cyc;
            if ($urandom_range(0, 7) == 0) m1_if.cyc = ~m1_if.cyc;
            m0_if.stb = 1'($urandom); m1_if.stb = 1'($urandom);
            m0_if.addr = $urandom; m1_if.addr = $urandom;
            m0_if.wdata = $urandom; m1_if.wdata = $urandom;
            m0_if.sel = 4'($urandom); m1_if.sel = 4'($urandom);
            m0_if.cti = 3'($urandom); m1_if.cti = 3'($urandom);
            m0_if.we = 1'($urandom); m1_if.we = 1'($urandom);
            s_if.stall = $urandom_range(0, 3) == 0;
            s_if.ack = $urandom_range(0, 2) == 0;
            s_if.rdata = $urandom;
            rst_ni = $urandom_range(0, 399) != 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
